alu_result_packer: RTL and testbench

- Downstream stage of the ALU top.
- Watches the four unit outputs and their valid flags (arith, logic, cmp, shift) and captures whichever result is valid.
- Serialises the captured result LSB-first into bytes over a valid/ready handshake toward the UART TX path.
- Asserts busy so the system controller holds off new ALU operations until the frame has drained.

---
 rtl/alu_result_packer.sv | 113 +++++++++++
 tb/tb_alu_result_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_packer.sv
// Captures one valid ALU unit result and streams it out LSB-first as bytes
// over a valid/ready handshake, holding busy until the frame has drained.
module alu_result_packer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   arith_out,
    input  logic                 arith_flag,
    input  logic [WIDTH-1:0]     logic_out,
    input  logic                 logic_flag,
    input  logic [1:0]           cmp_out,
    input  logic                 cmp_flag,
    input  logic [WIDTH-1:0]     shift_out,
    input  logic                 shift_flag,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_multi,
    output logic                 drop
);

    localparam int unsigned MAX_BYTES  = 2 * WIDTH / 8;
    localparam int unsigned HALF_BYTES = WIDTH / 8;
    localparam int unsigned CW         = $clog2(MAX_BYTES + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   shiftReg;
    logic [CW-1:0]        count;

    logic [2*WIDTH-1:0]   selData;
    logic [CW-1:0]        selCount;
    logic                 anyFlag;
    logic                 multiFlag;

    assign anyFlag   = arith_flag | logic_flag | cmp_flag | shift_flag;
    assign multiFlag = (arith_flag & (logic_flag | cmp_flag | shift_flag))
                     | (logic_flag & (cmp_flag | shift_flag))
                     | (cmp_flag & shift_flag);

    // Priority arith > logic > cmp > shift; narrower results are zero-extended.
    always_comb begin
        selData  = '0;
        selCount = '0;
        if (arith_flag) begin
            selData  = arith_out;
            selCount = CW'(MAX_BYTES);
        end else if (logic_flag) begin
            selData  = {{WIDTH{1'b0}}, logic_out};
            selCount = CW'(HALF_BYTES);
        end else if (cmp_flag) begin
            selData  = {{(2*WIDTH-2){1'b0}}, cmp_out};
            selCount = CW'(1);
        end else if (shift_flag) begin
            selData  = {{WIDTH{1'b0}}, shift_out};
            selCount = CW'(HALF_BYTES);
        end
    end

    assign tx_data = shiftReg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shiftReg   <= '0;
            count      <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_multi  <= 1'b0;
            drop       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_multi  <= 1'b0;
            drop       <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyFlag) begin
                        shiftReg  <= selData;
                        count     <= selCount;
                        state     <= SEND;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        err_multi <= multiFlag;
                    end
                end
                SEND: begin
                    // Flags during a frame are reported but never disturb it.
                    drop <= anyFlag;
                    if (tx_ready) begin
                        shiftReg <= shiftReg >> 8;
                        count    <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state      <= IDLE;
                            tx_valid   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_packer.sv
// Scoreboard bench: a queue-based model of the byte frame is filled on capture
// and checked against the DUT every cycle on the falling edge.
module tb_alu_result_packer;

    localparam int unsigned WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [2*WIDTH-1:0] arith_out;
    logic               arith_flag;
    logic [WIDTH-1:0]   logic_out;
    logic               logic_flag;
    logic [1:0]         cmp_out;
    logic               cmp_flag;
    logic [WIDTH-1:0]   shift_out;
    logic               shift_flag;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               frame_done;
    logic               err_multi;
    logic               drop;

    always #5 clk = ~clk;

    alu_result_packer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .arith_out  (arith_out),
        .arith_flag (arith_flag),
        .logic_out  (logic_out),
        .logic_flag (logic_flag),
        .cmp_out    (cmp_out),
        .cmp_flag   (cmp_flag),
        .shift_out  (shift_out),
        .shift_flag (shift_flag),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .err_multi  (err_multi),
        .drop       (drop)
    );

    int checks = 0;
    int errors = 0;

    // Bytes of the frame still owed to the sink, front = byte on the wire.
    byte unsigned frameQ[$];
    bit expFd   = 1'b0;
    bit expEm   = 1'b0;
    bit expDrop = 1'b0;
    bit modelLive = 1'b0;

    always @(posedge clk) begin : model
        int nf;
        int n;
        longint unsigned v;
        nf = int'(arith_flag) + int'(logic_flag) + int'(cmp_flag) + int'(shift_flag);
        expFd   = 1'b0;
        expEm   = 1'b0;
        expDrop = 1'b0;
        if (rst) begin
            frameQ.delete();
            modelLive = 1'b1;
        end else if (frameQ.size() > 0) begin
            if (nf > 0) expDrop = 1'b1;
            if (tx_ready) begin
                void'(frameQ.pop_front());
                if (frameQ.size() == 0) expFd = 1'b1;
            end
        end else if (nf > 0) begin
            if (arith_flag) begin
                v = longint'(arith_out); n = 2 * WIDTH / 8;
            end else if (logic_flag) begin
                v = longint'(logic_out); n = WIDTH / 8;
            end else if (cmp_flag) begin
                v = longint'(cmp_out);   n = 1;
            end else begin
                v = longint'(shift_out); n = WIDTH / 8;
            end
            for (int i = 0; i < n; i++)
                frameQ.push_back(8'((v >> (8 * i)) % 256));
            expEm = (nf > 1);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        if (modelLive) begin
            check("tx_valid",   32'(tx_valid),   32'(frameQ.size() > 0));
            check("busy",       32'(busy),       32'(frameQ.size() > 0));
            check("frame_done", 32'(frame_done), 32'(expFd));
            check("err_multi",  32'(err_multi),  32'(expEm));
            check("drop",       32'(drop),       32'(expDrop));
            if (frameQ.size() > 0)
                check("tx_data",      32'(tx_data), 32'(frameQ[0]));
            else
                check("tx_data_idle", 32'(tx_data), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clearFlags();
        arith_flag = 1'b0;
        logic_flag = 1'b0;
        cmp_flag   = 1'b0;
        shift_flag = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (frameQ.size() > 0 && n < 200) begin
            step();
            n++;
        end
        if (frameQ.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL waitIdle: %0d bytes still pending, expected 0", frameQ.size());
        end
    endtask

    initial begin : driver
        bit ph;
        rst = 1'b1;
        clearFlags();
        arith_out = '0; logic_out = '0; cmp_out = '0; shift_out = '0;
        tx_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Arith frame, sink always ready.
        arith_out = 32'h1234_5678; arith_flag = 1'b1; tx_ready = 1'b1;
        step(); clearFlags();
        waitIdle(); step();

        // Logic frame with sink alternating not-ready / ready.
        logic_out = 16'hFFF0; logic_flag = 1'b1; tx_ready = 1'b0;
        step(); clearFlags();
        ph = 1'b0;
        for (int i = 0; i < 20 && frameQ.size() > 0; i++) begin
            tx_ready = ph;
            step();
            ph = ~ph;
        end
        waitIdle(); tx_ready = 1'b1; step();

        // Single-byte compare frame.
        cmp_out = 2'b10; cmp_flag = 1'b1;
        step(); clearFlags();
        waitIdle(); step();

        // Two flags at once: arith wins, err_multi pulses.
        arith_out = 32'h0000_0005; shift_out = 16'h0014;
        arith_flag = 1'b1; shift_flag = 1'b1;
        step(); clearFlags();
        waitIdle(); step();

        // Flag while stalled mid-frame is dropped.
        arith_out = 32'hA1B2_C3D4; arith_flag = 1'b1; tx_ready = 1'b0;
        step(); clearFlags();
        step();
        shift_out = 16'h000A; shift_flag = 1'b1;
        step(); clearFlags();
        step();
        tx_ready = 1'b1;
        waitIdle(); step();

        // Reset after two of four bytes accepted, then a clean compare frame.
        arith_out = 32'hDEAD_BEEF; arith_flag = 1'b1; tx_ready = 1'b1;
        step(); clearFlags();
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        cmp_out = 2'b01; cmp_flag = 1'b1;
        step(); clearFlags();
        waitIdle(); step();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            arith_out  = $urandom();
            logic_out  = 16'($urandom());
            cmp_out    = 2'($urandom());
            shift_out  = 16'($urandom());
            arith_flag = ($urandom_range(0, 7) == 0);
            logic_flag = ($urandom_range(0, 7) == 0);
            cmp_flag   = ($urandom_range(0, 7) == 0);
            shift_flag = ($urandom_range(0, 7) == 0);
            tx_ready   = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;
        clearFlags();
        tx_ready = 1'b1;
        waitIdle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
